// File: rtl/tmds_channel_encoder_pkg.sv
// Shared TMDS constants and helpers for the HDMI TX colour-channel encoders.
package tmds_channel_encoder_pkg;

  localparam int unsigned TMDS_W    = 10;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CNT_W_DEF = 5;

  localparam logic [TMDS_W-1:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] CTRL_TOK_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [DATA_W-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// Three-stage DVI TMDS 8b/10b channel encoder with running DC-disparity tracking.
module tmds_channel_encoder
  import tmds_channel_encoder_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   din,
  input  logic                c0,
  input  logic                c1,
  input  logic                de,
  output logic [TMDS_W-1:0]   dout
);

  // Stage 1
  logic [DATA_W-1:0] din_q;
  logic              de1_q;
  logic [1:0]        c1_q;
  logic [3:0]        n1d_q;

  // Stage 2
  logic              decision1;
  logic [8:0]        qm_d, qm_q;
  logic [3:0]        n1q_d, n1q_q, n0q_q;
  logic              de2_q;
  logic [1:0]        c2_q;

  // Stage 3
  logic [TMDS_W-1:0]       dout_d, dout_q;
  logic signed [CNT_W-1:0] cnt_d, cnt_q;
  logic signed [CNT_W-1:0] n1s, n0s, q8s, nq8s;
  logic                    cnt_pos, cnt_neg;

  always_comb begin
    decision1 = (n1d_q > 4'd4) || ((n1d_q == 4'd4) && !din_q[0]);
    qm_d      = '0;
    qm_d[0]   = din_q[0];
    // XNOR chain expressed as XOR with decision1 folded in
    for (int unsigned i = 1; i < DATA_W; i++) begin
      qm_d[i] = qm_d[i-1] ^ din_q[i] ^ decision1;
    end
    qm_d[8] = ~decision1;
    n1q_d   = popcount8(qm_d[7:0]);
  end

  always_comb begin
    n1s     = {{(CNT_W-4){1'b0}}, n1q_q};
    n0s     = {{(CNT_W-4){1'b0}}, n0q_q};
    q8s     = {{(CNT_W-1){1'b0}}, qm_q[8]};
    nq8s    = {{(CNT_W-1){1'b0}}, ~qm_q[8]};
    cnt_neg = cnt_q[CNT_W-1];
    cnt_pos = !cnt_q[CNT_W-1] && (cnt_q != '0);
    dout_d  = '0;
    cnt_d   = cnt_q;
    if (!de2_q) begin
      cnt_d = '0;
      unique case (c2_q)
        2'b00: dout_d = CTRL_TOK_00;
        2'b01: dout_d = CTRL_TOK_01;
        2'b10: dout_d = CTRL_TOK_10;
        2'b11: dout_d = CTRL_TOK_11;
      endcase
    end else if ((cnt_q == '0) || (n1q_q == n0q_q)) begin
      dout_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d  = qm_q[8] ? (cnt_q + n1s - n0s) : (cnt_q + n0s - n1s);
    end else if ((cnt_pos && (n1q_q > n0q_q)) || (cnt_neg && (n0q_q > n1q_q))) begin
      dout_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d  = cnt_q + q8s + q8s + n0s - n1s;
    end else begin
      dout_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d  = cnt_q - nq8s - nq8s + n1s - n0s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      din_q  <= '0;
      de1_q  <= 1'b0;
      c1_q   <= '0;
      n1d_q  <= '0;
      qm_q   <= '0;
      n1q_q  <= '0;
      n0q_q  <= '0;
      de2_q  <= 1'b0;
      c2_q   <= '0;
      dout_q <= '0;
      cnt_q  <= '0;
    end else begin
      din_q  <= din;
      de1_q  <= de;
      c1_q   <= {c1, c0};
      n1d_q  <= popcount8(din);
      qm_q   <= qm_d;
      n1q_q  <= n1q_d;
      n0q_q  <= 4'd8 - n1q_d;
      de2_q  <= de1_q;
      c2_q   <= c1_q;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Randomised self-checking bench for tmds_channel_encoder with a behavioural TMDS model.
module tb_tmds_channel_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       c0, c1, de;
  logic [9:0] dout;

  int checks = 0;
  int errors = 0;

  tmds_channel_encoder #(.CNT_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .c0   (c0),
    .c1   (c1),
    .de   (de),
    .dout (dout)
  );

  always #5 clk = ~clk;

  // Model: delay line of raw inputs, encoding applied on the third edge.
  logic       s1_de, s2_de;
  logic [1:0] s1_c, s2_c;
  logic [7:0] s1_d, s2_d;
  int         mcnt = 0;
  logic [9:0] exp_dout;
  logic       exp_is_data = 1'b0;
  logic [7:0] exp_din;
  logic       started = 1'b0;

  function automatic int ones8(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic enc_model(input logic [7:0] d, input int cin,
                           output logic [9:0] sym, output int cout);
    int         n1, ones, zeros, q8;
    logic       inv;
    logic [7:0] qm;
    n1    = ones8(d);
    inv   = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = inv ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    q8    = inv ? 0 : 1;
    ones  = ones8(qm);
    zeros = 8 - ones;
    if (cin == 0 || ones == zeros) begin
      if (q8 == 1) begin sym = {2'b01, qm};  cout = cin + ones - zeros; end
      else         begin sym = {2'b10, ~qm}; cout = cin + zeros - ones; end
    end else if ((cin > 0 && ones > zeros) || (cin < 0 && zeros > ones)) begin
      sym  = {1'b1, q8[0], ~qm};
      cout = cin + 2 * q8 + zeros - ones;
    end else begin
      sym  = {1'b0, q8[0], qm};
      cout = cin - 2 * (1 - q8) + ones - zeros;
    end
  endtask

  always @(posedge clk) begin
    logic [9:0] sym;
    int         nc;
    started <= 1'b1;
    if (reset) begin
      s1_de = 0; s2_de = 0; s1_c = 0; s2_c = 0; s1_d = 0; s2_d = 0;
      mcnt = 0; exp_dout = 10'h000; exp_is_data = 1'b0;
    end else begin
      if (s2_de) begin
        enc_model(s2_d, mcnt, sym, nc);
        exp_dout = sym; mcnt = nc; exp_is_data = 1'b1; exp_din = s2_d;
      end else begin
        mcnt = 0; exp_is_data = 1'b0;
        case (s2_c)
          2'd0: exp_dout = 10'h354;
          2'd1: exp_dout = 10'h0AB;
          2'd2: exp_dout = 10'h154;
          default: exp_dout = 10'h2AB;
        endcase
      end
      s2_de = s1_de; s2_c = s1_c; s2_d = s1_d;
      s1_de = de; s1_c = {c1, c0}; s1_d = din;
    end
  end

  always @(negedge clk) begin
    logic [7:0] q, dec;
    if (started) begin
      checks++;
      if (dout !== exp_dout) begin
        errors++;
        $display("FAIL model_dout t=%0t got %h exp %h", $time, dout, exp_dout);
      end
      checks++;
      if (mcnt > 10 || mcnt < -10 || int'(dut.cnt_q) > 10 || int'(dut.cnt_q) < -10) begin
        errors++;
        $display("FAIL cnt_bound t=%0t dut %0d model %0d exp |cnt|<=10", $time, int'(dut.cnt_q), mcnt);
      end
      if (exp_is_data) begin
        q      = dout[9] ? ~dout[7:0] : dout[7:0];
        dec[0] = q[0];
        for (int i = 1; i < 8; i++) dec[i] = dout[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        checks++;
        if (dec !== exp_din) begin
          errors++;
          $display("FAIL decode t=%0t got %h exp %h", $time, dec, exp_din);
        end
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic [1:0] c, input logic [7:0] d);
    reset = r; de = e; {c1, c0} = c; din = d;
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [9:0] exp);
    checks++;
    if (dout !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, dout, exp);
    end
  endtask

  task automatic cntlit(input string nm, input int exp);
    checks++;
    if (mcnt != exp) begin
      errors++;
      $display("FAIL %s model cnt got %0d exp %0d", nm, mcnt, exp);
    end
  endtask

  initial begin
    reset = 1'b1; de = 1'b1; c0 = 1'b0; c1 = 1'b0; din = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 2'd0, 8'($urandom));
      lit("reset_hold", 10'h000);
    end
    step(1'b0, 1'b0, 2'd0, 8'h00); lit("reset_release", 10'h354);

    step(1'b0, 1'b0, 2'd0, 8'h00);
    step(1'b0, 1'b0, 2'd1, 8'h00);
    step(1'b0, 1'b0, 2'd2, 8'h00); lit("tok00", 10'h354);
    step(1'b0, 1'b0, 2'd3, 8'h00); lit("tok01", 10'h0AB);
    step(1'b0, 1'b1, 2'd0, 8'h00); lit("tok10", 10'h154);
    step(1'b0, 1'b1, 2'd0, 8'h00); lit("tok11", 10'h2AB);
    step(1'b0, 1'b1, 2'd0, 8'h00); lit("zero0", 10'h100); cntlit("zero0_cnt", -8);
    step(1'b0, 1'b1, 2'd0, 8'h00); lit("zero1", 10'h3FF); cntlit("zero1_cnt", 2);
    step(1'b0, 1'b0, 2'd0, 8'h00); lit("zero2", 10'h100); cntlit("zero2_cnt", -6);
    step(1'b0, 1'b0, 2'd0, 8'h00); lit("zero3", 10'h3FF); cntlit("zero3_cnt", 4);

    step(1'b0, 1'b1, 2'd0, 8'hFF); lit("blank_a", 10'h354);
    step(1'b0, 1'b1, 2'd0, 8'hFF); lit("blank_b", 10'h354);
    step(1'b0, 1'b0, 2'd0, 8'h00); lit("ones0", 10'h200); cntlit("ones0_cnt", -8);
    step(1'b0, 1'b1, 2'd0, 8'hFF); lit("ones1", 10'h0FF); cntlit("ones1_cnt", -2);
    step(1'b0, 1'b1, 2'd0, 8'hFF); lit("line_gap", 10'h354);
    step(1'b0, 1'b1, 2'd0, 8'hFF); lit("line_restart", 10'h200); cntlit("restart_cnt", -8);

    step(1'b1, 1'b1, 2'd0, 8'($urandom)); lit("mid_reset", 10'h000);
    step(1'b0, 1'b1, 2'd0, 8'h00); lit("post_rst0", 10'h354);
    step(1'b0, 1'b1, 2'd0, 8'h00); lit("post_rst1", 10'h354);
    step(1'b0, 1'b1, 2'd0, 8'h00); lit("post_rst2", 10'h100);

    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 7) != 0),
           2'($urandom_range(0, 3)), 8'($urandom));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'd0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
